// File: rtl/rst_seq_multi.sv
// rst_seq_multi: PLL-lock gated reset sequencer; releases N_OUT active-low domains one at a time
// and pulls them all back on lock loss or a software reset request.
module rst_seq_multi #(
    parameter int N_OUT       = 4,
    parameter int LOCK_FILT   = 4,
    parameter int RELEASE_DLY = 225,
    parameter int STAGE_DLY   = 16,
    parameter int SWRST_LEN   = 32
) (
    input  logic             CLK_IN,
    input  logic             RESET,
    input  logic             PLL_OK,
    input  logic             SW_RST_REQ,
    output logic [N_OUT-1:0] n_RESET_OUT,
    output logic             RST_DONE,
    output logic [2:0]       SEQ_STATE,
    output logic [7:0]       LOCK_LOSS
);
    localparam int MAX_A = (RELEASE_DLY > STAGE_DLY) ? RELEASE_DLY : STAGE_DLY;
    localparam int MAX_D = (MAX_A > SWRST_LEN) ? MAX_A : SWRST_LEN;
    localparam int CW    = $clog2(MAX_D + 1);
    localparam int FW    = $clog2(LOCK_FILT + 1);

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        LOCK_WAIT = 3'd1,
        STAGGER   = 3'd2,
        RUN       = 3'd3,
        SWRST     = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       sync_ff;
    logic [FW-1:0]    filt;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [N_OUT-1:0] out_nx, out_step;
    logic             synced, locked, lost, sw_ok;

    assign synced    = sync_ff[1];
    assign locked    = filt == FW'(LOCK_FILT);
    assign lost      = !synced && state != HOLD;
    assign sw_ok     = state == LOCK_WAIT || state == STAGGER || state == RUN;
    assign out_step  = N_OUT'({n_RESET_OUT, 1'b1});
    assign RST_DONE  = state == RUN;
    assign SEQ_STATE = state;

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            sync_ff     <= '0;
            filt        <= '0;
            state       <= HOLD;
            cnt         <= '0;
            n_RESET_OUT <= '0;
            LOCK_LOSS   <= '0;
        end else begin
            sync_ff     <= {sync_ff[0], PLL_OK};
            filt        <= !synced ? '0 : locked ? filt : filt + 1'b1;
            state       <= state_nx;
            cnt         <= cnt_nx;
            n_RESET_OUT <= out_nx;
            if (lost && LOCK_LOSS != 8'hFF)
                LOCK_LOSS <= LOCK_LOSS + 8'd1;
        end
    end

    // priority: lock loss, then software request, then normal sequencing
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        out_nx   = n_RESET_OUT;
        case (state)
            HOLD: begin
                cnt_nx = '0;
                out_nx = '0;
                if (locked && synced)
                    state_nx = LOCK_WAIT;
            end
            LOCK_WAIT: if (cnt == CW'(RELEASE_DLY)) begin
                state_nx = (N_OUT == 1) ? RUN : STAGGER;
                cnt_nx   = '0;
                out_nx   = N_OUT'(1);
            end
            STAGGER: if (cnt == CW'(STAGE_DLY - 1)) begin
                cnt_nx = '0;
                out_nx = out_step;
                if (&out_step)
                    state_nx = RUN;
            end
            RUN: cnt_nx = '0;
            SWRST: begin
                out_nx = '0;
                if (SW_RST_REQ)
                    cnt_nx = '0;
                else if (cnt == CW'(SWRST_LEN - 1)) begin
                    state_nx = LOCK_WAIT;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = HOLD;
                cnt_nx   = '0;
                out_nx   = '0;
            end
        endcase
        if (SW_RST_REQ && sw_ok) begin
            state_nx = SWRST;
            cnt_nx   = '0;
            out_nx   = '0;
        end
        if (lost) begin
            state_nx = HOLD;
            cnt_nx   = '0;
            out_nx   = '0;
        end
    end
endmodule

// File: tb/tb_rst_seq_multi.sv
// tb_rst_seq_multi: scoreboard bench; a timeline model predicts every output change of rst_seq_multi
// and a monitor pops and compares each change the DUT actually makes.
module tb_rst_seq_multi;
    localparam int N  = 4;
    localparam int LF = 4;
    localparam int RD = 225;
    localparam int SD = 16;
    localparam int SL = 32;

    typedef struct {
        int          t;
        logic [N+11:0] v;
    } ev_t;

    logic          CLK_IN = 0;
    logic          RESET = 1;
    logic          PLL_OK = 0;
    logic          SW_RST_REQ = 0;
    logic [N-1:0]  n_RESET_OUT;
    logic          RST_DONE;
    logic [2:0]    SEQ_STATE;
    logic [7:0]    LOCK_LOSS;

    ev_t           exp_q[$];
    int            checks = 0;
    int            failures = 0;
    bit            mon_en = 0;
    int            mc = 0;

    rst_seq_multi #(
        .N_OUT(N), .LOCK_FILT(LF), .RELEASE_DLY(RD), .STAGE_DLY(SD), .SWRST_LEN(SL)
    ) dut (
        .CLK_IN(CLK_IN), .RESET(RESET), .PLL_OK(PLL_OK), .SW_RST_REQ(SW_RST_REQ),
        .n_RESET_OUT(n_RESET_OUT), .RST_DONE(RST_DONE), .SEQ_STATE(SEQ_STATE), .LOCK_LOSS(LOCK_LOSS)
    );

    always #5 CLK_IN = ~CLK_IN;

    // Reference model: release times are arithmetic offsets from the edge the release clock started
    int            mt = 0, run = 0, base = 0, sw_t = 0, ll = 0;
    bit            h0 = 0, h1 = 0, hold = 1, in_sw = 0;
    logic [N+11:0] mprev = '0;
    always @(posedge CLK_IN) begin
        bit syn;
        int k, m, st;
        logic [N-1:0] o;
        logic [N+11:0] mcur;
        mt++;
        syn = h1;
        h1 = h0;
        h0 = PLL_OK;
        if (RESET) begin
            h0 = 0; h1 = 0; run = 0; hold = 1; in_sw = 0; ll = 0;
        end else begin
            run = syn ? ((run < 100) ? run + 1 : run) : 0;
            if (hold) begin
                if (run >= LF + 1) begin hold = 0; base = mt; end
            end else if (!syn) begin
                hold = 1; in_sw = 0; ll = (ll < 255) ? ll + 1 : 255;
            end else if (in_sw) begin
                if (SW_RST_REQ) sw_t = mt;
                else if (mt - sw_t == SL) begin in_sw = 0; base = mt; end
            end else if (SW_RST_REQ) begin
                in_sw = 1; sw_t = mt;
            end
        end
        o = '0;
        st = 0;
        if (!hold && in_sw) st = 4;
        else if (!hold) begin
            k = mt - base;
            if (k <= RD) st = 1;
            else begin
                m = 1 + (k - RD - 1) / SD;
                if (m > N) m = N;
                o = N'((1 << m) - 1);
                st = (m == N) ? 3 : 2;
            end
        end
        mcur = {o, st == 3, 3'(st), 8'(ll)};
        if (mcur !== mprev) begin
            exp_q.push_back('{mt, mcur});
            mprev = mcur;
        end
    end

    logic [N+11:0] dprev = '0;
    always @(negedge CLK_IN) begin
        logic [N+11:0] cur;
        ev_t e;
        mc++;
        cur = {n_RESET_OUT, RST_DONE, SEQ_STATE, LOCK_LOSS};
        if (mon_en && cur !== dprev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cycle=%0d got=%h required=no change", mc, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.t != mc || e.v !== cur) begin
                    failures++;
                    $display("FAIL output_event cycle=%0d got=%h required cycle=%0d value=%h", mc, cur, e.t, e.v);
                end
            end
            dprev = cur;
        end
    end

    task automatic step();
        @(negedge CLK_IN);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (mc < c) step();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h cycle=%0d", name, got, req, mc);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (SEQ_STATE !== s && n < budget) begin step(); n++; end
        chk("wait_state", 32'(SEQ_STATE), 32'(s));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=running required=finished", mc);
        $fatal(1, "timeout");
    end

    initial begin
        int e0, r, d;
        repeat (5) step();
        chk("reset_out", 32'(n_RESET_OUT), 0);
        chk("reset_done", 32'(RST_DONE), 0);
        chk("reset_state", 32'(SEQ_STATE), 0);
        chk("reset_lossc", 32'(LOCK_LOSS), 0);
        mon_en = 1;
        // power-up release timeline
        RESET = 0;
        PLL_OK = 1;
        e0 = mc + 1;
        wait_until(e0 + 231); chk("t1_pre_bit0", 32'(n_RESET_OUT), 0);
        wait_until(e0 + 232); chk("t1_bit0", 32'(n_RESET_OUT), 1);
        wait_until(e0 + 247); chk("t1_pre_bit1", 32'(n_RESET_OUT), 1);
        wait_until(e0 + 248); chk("t1_bit1", 32'(n_RESET_OUT), 3);
        wait_until(e0 + 264); chk("t1_bit2", 32'(n_RESET_OUT), 7);
        wait_until(e0 + 279); chk("t1_pre_done", 32'(RST_DONE), 0);
        wait_until(e0 + 280);
        chk("t1_bit3", 32'(n_RESET_OUT), 15);
        chk("t1_done", 32'(RST_DONE), 1);
        chk("t1_state", 32'(SEQ_STATE), 3);
        // lock filter restart from a one-sample dip
        PLL_OK = 0;
        RESET = 1;
        repeat (2) step();
        RESET = 0;
        repeat (3) step();
        PLL_OK = 1;
        repeat (3) step();
        PLL_OK = 0;
        step();
        PLL_OK = 1;
        e0 = mc + 1;
        wait_until(e0 + 231); chk("t2_pre_bit0", 32'(n_RESET_OUT), 0);
        wait_until(e0 + 232); chk("t2_bit0", 32'(n_RESET_OUT), 1);
        chk("t2_lossc", 32'(LOCK_LOSS), 0);
        // lock loss in RUN
        wait_state(3, 100);
        PLL_OK = 0;
        e0 = mc + 1;
        wait_until(e0 + 1); chk("t3_still_out", 32'(n_RESET_OUT), 15);
        wait_until(e0 + 2);
        chk("t3_out", 32'(n_RESET_OUT), 0);
        chk("t3_state", 32'(SEQ_STATE), 0);
        chk("t3_lossc", 32'(LOCK_LOSS), 1);
        PLL_OK = 1;
        e0 = mc + 1;
        wait_until(e0 + 232); chk("t3_rebit0", 32'(n_RESET_OUT), 1);
        wait_state(3, 100);
        // software reset from RUN
        step();
        SW_RST_REQ = 1;
        r = mc + 1;
        step();
        SW_RST_REQ = 0;
        chk("t4_out", 32'(n_RESET_OUT), 0);
        chk("t4_state", 32'(SEQ_STATE), 4);
        wait_until(r + SL - 1); chk("t4_swrst", 32'(SEQ_STATE), 4);
        wait_until(r + SL); chk("t4_lockwait", 32'(SEQ_STATE), 1);
        wait_until(r + SL + 225); chk("t4_pre_bit0", 32'(n_RESET_OUT), 0);
        wait_until(r + SL + 226); chk("t4_bit0", 32'(n_RESET_OUT), 1);
        // lock loss and request landing on the same edge in STAGGER
        wait_state(2, 100);
        step();
        PLL_OK = 0;
        d = mc + 1;
        step();
        step();
        SW_RST_REQ = 1;
        step();
        SW_RST_REQ = 0;
        chk("t5_mc", mc, d + 2);
        chk("t5_state", 32'(SEQ_STATE), 0);
        chk("t5_lossc", 32'(LOCK_LOSS), 2);
        step();
        chk("t5_no_swrst", 32'(SEQ_STATE), 0);
        // lock-loss counter saturation, then RESET in STAGGER
        repeat (300) begin
            PLL_OK = 1;
            repeat (7) step();
            PLL_OK = 0;
            step();
        end
        PLL_OK = 1;
        repeat (3) step();
        chk("t6_sat", 32'(LOCK_LOSS), 255);
        wait_state(2, 400);
        repeat (5) step();
        RESET = 1;
        step();
        RESET = 0;
        chk("t6_out", 32'(n_RESET_OUT), 0);
        chk("t6_done", 32'(RST_DONE), 0);
        chk("t6_lossc", 32'(LOCK_LOSS), 0);
        chk("t6_state", 32'(SEQ_STATE), 0);
        // randomized dips and requests, scoreboard only
        repeat (25) begin
            int n, a;
            PLL_OK = 1;
            n = $urandom_range(1, 350);
            repeat (n) step();
            a = $urandom_range(0, 3);
            if (a == 0) begin
                PLL_OK = 0;
                repeat ($urandom_range(1, 3)) step();
            end else if (a == 1) begin
                SW_RST_REQ = 1;
                step();
                SW_RST_REQ = 0;
            end else if (a == 2) begin
                SW_RST_REQ = 1;
                PLL_OK = 0;
                step();
                SW_RST_REQ = 0;
            end
        end
        PLL_OK = 1;
        repeat (5) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
